// File: rtl/xor_stream_cipher.sv
// Streaming XOR cipher: valid/ready data path ciphered against either a static
// key or a Galois-LFSR keystream that steps once per accepted beat.
module xor_stream_cipher #(
   parameter int                DATA_W = 8,
   parameter logic [DATA_W-1:0] TAPS   = 8'hB8,
   parameter int                CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              key_load,
   input  logic [DATA_W-1:0] key_in,
   input  logic              mode,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  beat_count
);

   logic [DATA_W-1:0] static_key;
   logic [DATA_W-1:0] lfsr_state;
   logic [DATA_W-1:0] lfsr_next;
   logic [DATA_W-1:0] key_sel;
   logic              accept;

   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;
   assign key_sel   = mode ? lfsr_state : static_key;
   assign lfsr_next = (lfsr_state >> 1) ^ (lfsr_state[0] ? TAPS : '0);

   // Output stage: a single result register that holds under backpressure
   // and keeps its data after draining.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= in_data ^ key_sel;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Key state and beat counter; a key load takes priority over the LFSR step
   // and the count, while the coinciding beat still used the old key above.
   always_ff @(posedge clk) begin
      if (rst) begin
         static_key <= '0;
         lfsr_state <= DATA_W'(1);
         beat_count <= '0;
      end else if (key_load) begin
         static_key <= key_in;
         lfsr_state <= (key_in == '0) ? DATA_W'(1) : key_in;
         beat_count <= '0;
      end else if (accept) begin
         if (mode)
            lfsr_state <= lfsr_next;
         beat_count <= beat_count + CNT_W'(1);
      end
   end

endmodule
